// File: rtl/conv_accum_relu_pkg.sv
// Shared definitions for the conv accumulate / ReLU output stage and the
// dense-layer output path that reuses relu_sat.
package conv_accum_relu_pkg;

   // Default datapath widths: activation/weight width, partial-sum width,
   // pixel address width (784 pixels fit in 10 bits).
   localparam int DEF_SIZE   = 11;
   localparam int DEF_ACC_W  = 24;
   localparam int DEF_ADDR_W = 10;

   // Pixel provenance tags used by the window generator upstream.
   typedef enum logic [1:0] {
      PROV_INNER = 2'b00,
      PROV_RIGHT = 2'b10,
      PROV_LEFT  = 2'b11
   } prov_e;

   // Largest positive activation representable in a signed size-bit word.
   function automatic int max_act(input int size);
      return (2 ** (size - 1)) - 1;
   endfunction

   localparam int MAX_ACT = (2 ** (DEF_SIZE - 1)) - 1;

endpackage

// File: rtl/conv_accum_relu_relu_sat.sv
// Combinational output conditioning: arithmetic right shift, ReLU and clamp
// to the positive range of an OUT_W-bit signed activation.
module relu_sat
   import conv_accum_relu_pkg::*;
#(
   parameter int IN_W  = DEF_ACC_W + 1,
   parameter int OUT_W = DEF_SIZE
) (
   input  logic [IN_W-1:0]  din,
   input  logic [3:0]       shift,
   output logic [OUT_W-1:0] dout
);

   localparam logic [IN_W-1:0]  MAX_IN  = IN_W'(max_act(OUT_W));
   localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(max_act(OUT_W));

   logic [IN_W-1:0] shifted;

   // Shift first, then squash negatives to zero and clamp large positives.
   always_comb begin
      shifted = IN_W'($signed(din) >>> shift);
      if (shifted[IN_W-1]) begin
         dout = '0;
      end else if (shifted > MAX_IN) begin
         dout = MAX_OUT;
      end else begin
         dout = shifted[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/conv_accum_relu.sv
// Conv engine output stage: accumulates per-pixel partial sums across input
// channels in an external RAM, then on the last channel adds bias, shifts,
// applies ReLU with saturation and emits one activation per pixel.
// Two pipeline stages: S0 issues the RAM read, S1 adds and writes back or
// produces the activation. A one-entry skid resolves address-bus conflicts.
module conv_accum_relu
   import conv_accum_relu_pkg::*;
#(
   parameter int SIZE   = DEF_SIZE,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  y_valid,
   input  logic [2*SIZE-2:0]     y_in,
   input  logic [ADDR_W-1:0]     y_addr,
   input  logic                  first_chan,
   input  logic                  last_chan,
   input  logic [SIZE-1:0]       bias,
   input  logic [3:0]            shift,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic                  ram_we,
   output logic [ACC_W-1:0]      ram_wdata,
   input  logic [ACC_W-1:0]      ram_rdata,
   output logic                  out_valid,
   output logic [ADDR_W-1:0]     out_addr,
   output logic [SIZE-1:0]       out_data,
   output logic                  busy
);

   localparam int YW = 2 * SIZE - 1;
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   // Skid entry: holds a beat whose read lost the address bus to an S1 write.
   logic              skid_valid_reg;
   logic [YW-1:0]     skid_y_reg;
   logic [ADDR_W-1:0] skid_addr_reg;
   logic              skid_first_reg;
   logic              skid_last_reg;

   // S0 view: the skid beat takes priority over the live input.
   logic              s0_valid;
   logic [YW-1:0]     s0_y;
   logic [ADDR_W-1:0] s0_addr;
   logic              s0_first;
   logic              s0_last;
   logic [ACC_W-1:0]  s0_y_ext;

   // S1 registers.
   logic              s1_valid_reg;
   logic [ACC_W-1:0]  s1_y_reg;
   logic [ADDR_W-1:0] s1_addr_reg;
   logic              s1_first_reg;
   logic              s1_last_reg;
   logic              s1_fwd_reg;
   logic [ACC_W-1:0]  s1_fwd_sum_reg;

   // Control and datapath nets.
   logic              s1_we;
   logic              fwd_hit;
   logic              need_read;
   logic              stall;
   logic              advance;
   logic [ACC_W-1:0]  prev;
   logic [ACC_W:0]    wide_sum;
   logic [ACC_W-1:0]  sum;
   logic [ACC_W:0]    biased;
   logic [SIZE-1:0]   act;

   // Select the beat presented to S0 and sign-extend its conv sum.
   always_comb begin
      s0_valid = skid_valid_reg | y_valid;
      s0_y     = skid_valid_reg ? skid_y_reg     : y_in;
      s0_addr  = skid_valid_reg ? skid_addr_reg  : y_addr;
      s0_first = skid_valid_reg ? skid_first_reg : first_chan;
      s0_last  = skid_valid_reg ? skid_last_reg  : last_chan;
      s0_y_ext = {{(ACC_W-YW){s0_y[YW-1]}}, s0_y};
   end

   // Address arbitration: an S1 write owns the bus; a same-address beat
   // takes the S1 sum directly and needs no read, so it never stalls.
   always_comb begin
      s1_we     = s1_valid_reg & ~s1_last_reg;
      fwd_hit   = s1_we & s0_valid & ~s0_first & (s1_addr_reg == s0_addr);
      need_read = s0_valid & ~s0_first & ~fwd_hit;
      stall     = need_read & s1_we;
      advance   = s0_valid & ~stall;
      ram_addr  = s1_we ? s1_addr_reg : s0_addr;
      ram_we    = s1_we;
   end

   // Accumulate with saturation to the signed ACC_W range, then add bias
   // one bit wider so the final sum cannot wrap before shifting.
   always_comb begin
      if (s1_first_reg) begin
         prev = '0;
      end else if (s1_fwd_reg) begin
         prev = s1_fwd_sum_reg;
      end else begin
         prev = ram_rdata;
      end
      wide_sum = {prev[ACC_W-1], prev} + {s1_y_reg[ACC_W-1], s1_y_reg};
      if (wide_sum[ACC_W] != wide_sum[ACC_W-1]) begin
         sum = wide_sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
         sum = wide_sum[ACC_W-1:0];
      end
      biased    = {sum[ACC_W-1], sum} + {{(ACC_W+1-SIZE){bias[SIZE-1]}}, bias};
      ram_wdata = sum;
      busy      = s1_valid_reg | skid_valid_reg;
   end

   relu_sat #(
      .IN_W  (ACC_W + 1),
      .OUT_W (SIZE)
   ) u_relu_sat (
      .din   (biased),
      .shift (shift),
      .dout  (act)
   );

   // Capture a beat into the skid when its read collides with an S1 write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_valid_reg <= 1'b0;
         skid_y_reg     <= '0;
         skid_addr_reg  <= '0;
         skid_first_reg <= 1'b0;
         skid_last_reg  <= 1'b0;
      end else begin
         skid_valid_reg <= stall;
         if (stall) begin
            skid_y_reg     <= s0_y;
            skid_addr_reg  <= s0_addr;
            skid_first_reg <= s0_first;
            skid_last_reg  <= s0_last;
         end
      end
   end

   // Advance the S0 beat into S1, remembering whether it forwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_reg   <= 1'b0;
         s1_y_reg       <= '0;
         s1_addr_reg    <= '0;
         s1_first_reg   <= 1'b0;
         s1_last_reg    <= 1'b0;
         s1_fwd_reg     <= 1'b0;
         s1_fwd_sum_reg <= '0;
      end else begin
         s1_valid_reg <= advance;
         if (advance) begin
            s1_y_reg       <= s0_y_ext;
            s1_addr_reg    <= s0_addr;
            s1_first_reg   <= s0_first;
            s1_last_reg    <= s0_last;
            s1_fwd_reg     <= fwd_hit;
            s1_fwd_sum_reg <= sum;
         end
      end
   end

   // Register the activation for last-channel beats as a one-cycle pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
      end else begin
         out_valid <= s1_valid_reg & s1_last_reg;
         if (s1_valid_reg & s1_last_reg) begin
            out_addr <= s1_addr_reg;
            out_data <= act;
         end
      end
   end

endmodule

// File: tb/tb_conv_accum_relu.sv
// Scoreboard bench for conv_accum_relu: stimulus pushes expected RAM writes
// and activations into queues; a monitor pops and compares on each strobe.
module tb_conv_accum_relu;

   localparam int SIZE   = 11;
   localparam int ACC_W  = 24;
   localparam int ADDR_W = 10;
   localparam int YW     = 2 * SIZE - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              y_valid = 1'b0;
   logic [YW-1:0]     y_in = '0;
   logic [ADDR_W-1:0] y_addr = '0;
   logic              first_chan = 1'b0;
   logic              last_chan = 1'b0;
   logic [SIZE-1:0]   bias = '0;
   logic [3:0]        shift = '0;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [ACC_W-1:0]  ram_wdata;
   logic [ACC_W-1:0]  ram_rdata = '0;
   logic              out_valid;
   logic [ADDR_W-1:0] out_addr;
   logic [SIZE-1:0]   out_data;
   logic              busy;

   logic [ACC_W-1:0]  mem [0:(1<<ADDR_W)-1];

   typedef struct {
      int addr;
      int data;
      int cyc;
   } exp_t;

   exp_t out_q[$];
   exp_t wr_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   conv_accum_relu dut (
      .clk        (clk),
      .rst        (rst),
      .y_valid    (y_valid),
      .y_in       (y_in),
      .y_addr     (y_addr),
      .first_chan (first_chan),
      .last_chan  (last_chan),
      .bias       (bias),
      .shift      (shift),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .out_valid  (out_valid),
      .out_addr   (out_addr),
      .out_data   (out_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Partial-sum RAM: registered read, read-during-write returns old data.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: compare every DUT strobe against the head of its queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (out_valid) begin
               if (out_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("[TB] FAIL unexpected_out: got addr=%0d data=%0d, expected none",
                           out_addr, out_data);
               end else begin
                  e = out_q.pop_front();
                  $display("[TB] out  addr=%0d data=%0d cyc=%0d", out_addr, out_data, cyc);
                  chk("out_addr", int'(out_addr), e.addr);
                  chk("out_data", int'(out_data), e.data);
                  chk("out_latency", cyc, e.cyc);
               end
            end
            if (ram_we) begin
               if (wr_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("[TB] FAIL unexpected_write: got addr=%0d data=%0h, expected none",
                           ram_addr, ram_wdata);
               end else begin
                  e = wr_q.pop_front();
                  $display("[TB] wr   addr=%0d data=%0h", ram_addr, ram_wdata);
                  chk("wr_addr", int'(ram_addr), e.addr);
                  chk("wr_data", int'(ram_wdata), e.data);
               end
            end
         end
      end
   end

   task automatic push_wr(input int addr, input int data);
      wr_q.push_back('{addr, data & 32'h00FF_FFFF, 0});
   endtask

   // Present one beat for one cycle (called just after a rising edge).
   task automatic beat(input int addr, input int y, input bit first, input bit last,
                       input bit gap, input int exp_out);
      y_valid    = 1'b1;
      y_in       = YW'(y);
      y_addr     = ADDR_W'(addr);
      first_chan = first;
      last_chan  = last;
      if (last) out_q.push_back('{addr, exp_out, cyc + 2});
      @(posedge clk);
      #1;
      y_valid = 1'b0;
      if (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Wait, bounded, for the pipeline and both queues to empty.
   task automatic drain(input string name);
      int k;
      k = 0;
      while ((out_q.size() != 0 || wr_q.size() != 0 || busy || out_valid) && k < 30) begin
         @(posedge clk);
         #2;
         k++;
      end
      tests++;
      if (k >= 30) begin
         fails++;
         $display("[TB] FAIL drain_%s: got %0d outs/%0d writes pending, expected 0",
                  name, out_q.size(), wr_q.size());
         out_q.delete();
         wr_q.delete();
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_ram_we", int'(ram_we), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_addr", int'(out_addr), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: single channel, (300+20)>>>2 = 80, no RAM write
      bias = 11'd20; shift = 4'd2;
      beat(3, 300, 1, 1, 1, 80);
      drain("t1");

      // 2: two channels at addr 5: 100 then -40 -> 60
      bias = '0; shift = '0;
      push_wr(5, 100);
      beat(5, 100, 1, 0, 1, 0);
      beat(5, -40, 0, 1, 1, 60);
      drain("t2");

      // 3: ReLU floor and clamp
      beat(10, -500, 1, 1, 1, 0);
      beat(11, 5000, 1, 1, 1, 1023);
      drain("t3");

      // 4: back-to-back same address uses the forwarded sum
      push_wr(7, 10);
      beat(7, 10, 1, 0, 1, 0);
      push_wr(7, 30);
      push_wr(7, 60);
      beat(7, 20, 0, 0, 0, 0);
      beat(7, 30, 0, 0, 1, 0);
      drain("t4");
      chk("mem7_after_fwd", int'(mem[7]), 60);
      beat(7, 0, 0, 1, 1, 60);
      drain("t4_out");

      // 4b: back-to-back different addresses, second beat goes through the skid
      push_wr(8, 1);
      beat(8, 1, 1, 0, 1, 0);
      push_wr(9, 2);
      beat(9, 2, 1, 0, 1, 0);
      push_wr(8, 6);
      push_wr(9, 9);
      beat(8, 5, 0, 0, 0, 0);
      chk("busy_skid", int'(busy), 1);
      beat(9, 7, 0, 0, 1, 0);
      drain("t4b");
      beat(8, 0, 0, 1, 1, 6);
      beat(9, 0, 0, 1, 1, 9);
      drain("t4b_out");

      // 5: accumulator saturates at both ends instead of wrapping
      mem[12] = 24'h7FFFF0;
      mem[13] = 24'h800010;
      push_wr(12, 32'h007F_FFFF);
      beat(12, 1000, 0, 0, 1, 0);
      push_wr(13, 32'h0080_0000);
      beat(13, -1000, 0, 0, 1, 0);
      drain("t5");
      shift = 4'd13;
      beat(12, 0, 0, 1, 1, 1023);
      beat(13, 0, 0, 1, 1, 0);
      drain("t5_out");

      // 6: reset while a middle-channel beat sits in S1 drops its write
      shift = '0;
      mem[20] = 24'd50;
      beat(20, 5, 0, 0, 0, 0);
      rst = 1'b1;
      #1;
      chk("rst_mid_ram_we", int'(ram_we), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_mid_mem20", int'(mem[20]), 50);
      chk("rst_mid_out_valid", int'(out_valid), 0);
      chk("rst_mid_busy", int'(busy), 0);
      beat(20, 5, 0, 1, 1, 55);
      drain("t6");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
